// File: rtl/decode_stage_if.sv
// Fetch-to-execute bus around the decode stage: raw instruction in, control bundle out.
// slave is the decode stage's view; master is the surrounding fetch/execute environment.
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_ins;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [1:0]      pcsel;
  logic            alu1sel;
  logic            alu2sel;
  logic [1:0]      wbsel;
  logic            regwrite;
  logic            memread;
  logic            memwrite;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm;
  logic            illegal;

  modport master (
    output in_valid, in_ins, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, pcsel, alu1sel, alu2sel, wbsel,
           regwrite, memread, memwrite, funct3, funct7b5, rs1, rs2, rd, imm, illegal
  );

  modport slave (
    input  in_valid, in_ins, in_pc, out_ready,
    output in_ready, out_valid, out_pc, pcsel, alu1sel, alu2sel, wbsel,
           regwrite, memread, memwrite, funct3, funct7b5, rs1, rs2, rd, imm, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: turns fetched instructions into an execute control bundle,
// buffered by an output register plus one skid entry so in_ready never sees out_ready combinationally.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter bit CSR_LEGAL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  decode_stage_if.slave bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [1:0]      pcsel;
    logic            alu1sel;
    logic            alu2sel;
    logic [1:0]      wbsel;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } bundle_t;

  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic        ill;
  logic        accept;
  bundle_t     dec;

  assign ins = bus.in_ins;
  assign opc = ins[6:0];
  assign f7  = ins[31:25];
  assign f3  = ins[14:12];

  // Stage p0: combinational decode of the instruction presented by fetch
  always_comb begin
    dec          = '0;
    ill          = 1'b0;
    dec.pc       = bus.in_pc;
    dec.funct3   = f3;
    dec.funct7b5 = ins[30];
    case (opc)
      OP_R: begin
        dec.rs1 = ins[19:15]; dec.rs2 = ins[24:20]; dec.rd = ins[11:7];
        dec.regwrite = 1'b1;
        ill = !((f7 == 7'b0) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OP_I: begin
        dec.rs1 = ins[19:15]; dec.rd = ins[11:7];
        dec.imm = sext32({{20{ins[31]}}, ins[31:20]});
        dec.alu2sel = 1'b1; dec.regwrite = 1'b1;
        if (f3 == 3'b001)      ill = (f7 != 7'b0);
        else if (f3 == 3'b101) ill = !(f7 == 7'b0 || f7 == 7'b0100000);
      end
      OP_LOAD: begin
        dec.rs1 = ins[19:15]; dec.rd = ins[11:7];
        dec.imm = sext32({{20{ins[31]}}, ins[31:20]});
        dec.alu2sel = 1'b1; dec.memread = 1'b1; dec.wbsel = 2'd1; dec.regwrite = 1'b1;
      end
      OP_STORE: begin
        dec.rs1 = ins[19:15]; dec.rs2 = ins[24:20];
        dec.imm = sext32({{20{ins[31]}}, ins[31:25], ins[11:7]});
        dec.memwrite = 1'b1;
      end
      OP_BRANCH: begin
        dec.rs1 = ins[19:15]; dec.rs2 = ins[24:20];
        dec.imm = sext32({{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        dec.pcsel = 2'd3;
      end
      OP_JAL: begin
        dec.rd = ins[11:7];
        dec.imm = sext32({{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        dec.pcsel = 2'd1; dec.wbsel = 2'd2; dec.regwrite = 1'b1;
      end
      OP_JALR: begin
        dec.rs1 = ins[19:15]; dec.rd = ins[11:7];
        dec.imm = sext32({{20{ins[31]}}, ins[31:20]});
        dec.pcsel = 2'd2; dec.wbsel = 2'd2; dec.regwrite = 1'b1;
        ill = (f3 != 3'b000);
      end
      OP_LUI, OP_AUIPC: begin
        dec.rd = ins[11:7];
        dec.imm = sext32({ins[31:12], 12'b0});
        dec.alu1sel = (opc == OP_AUIPC); dec.alu2sel = 1'b1; dec.regwrite = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: ill = !CSR_LEGAL;
      default: ill = 1'b1;
    endcase
    if (ins[1:0] != 2'b11) ill = 1'b1;
    if (dec.rd == 5'd0) dec.regwrite = 1'b0;
    // Illegal instructions still flow through, but with every side effect stripped
    if (ill) begin
      dec          = '0;
      dec.pc       = bus.in_pc;
      dec.funct3   = f3;
      dec.funct7b5 = ins[30];
      dec.illegal  = 1'b1;
    end
  end

  logic    vld_p1;
  logic    skid_vld_p1;
  bundle_t bnd_p1;
  bundle_t skid_p1;

  assign accept = bus.in_valid && !skid_vld_p1 && !flush;

  // Stage p1: output register with a one-entry skid behind it; skid always drains first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      bnd_p1      <= '0;
      skid_p1     <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (!vld_p1 || bus.out_ready) begin
      if (skid_vld_p1) begin
        bnd_p1      <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= accept;
        if (accept) bnd_p1 <= dec;
      end
    end else if (accept) begin
      skid_p1     <= dec;
      skid_vld_p1 <= 1'b1;
    end
  end

  assign bus.in_ready  = ~skid_vld_p1;
  assign bus.out_valid = vld_p1;
  assign bus.out_pc    = bnd_p1.pc;
  assign bus.pcsel     = bnd_p1.pcsel;
  assign bus.alu1sel   = bnd_p1.alu1sel;
  assign bus.alu2sel   = bnd_p1.alu2sel;
  assign bus.wbsel     = bnd_p1.wbsel;
  assign bus.regwrite  = bnd_p1.regwrite;
  assign bus.memread   = bnd_p1.memread;
  assign bus.memwrite  = bnd_p1.memwrite;
  assign bus.funct3    = bnd_p1.funct3;
  assign bus.funct7b5  = bnd_p1.funct7b5;
  assign bus.rs1       = bnd_p1.rs1;
  assign bus.rs2       = bnd_p1.rs2;
  assign bus.rd        = bnd_p1.rd;
  assign bus.imm       = bnd_p1.imm;
  assign bus.illegal   = bnd_p1.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed instructions with literal expectations, plus a queue-based
// reference model that checks occupancy and every bundle delivered to execute.
module tb_decode_stage;
  localparam bit CSR_LEGAL = 1'b0;

  logic clk;
  logic rst_n;
  logic flush;
  int   nchk = 0;
  int   nerr = 0;
  int   npop = 0;

  decode_stage_if #(.XLEN(32), .PC_W(32)) bus ();

  decode_stage #(.XLEN(32), .PC_W(32), .CSR_LEGAL(CSR_LEGAL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  pcsel;
    logic        alu1sel;
    logic        alu2sel;
    logic [1:0]  wbsel;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        illegal;
  } exp_t;

  typedef enum int {F_R, F_I, F_L, F_S, F_B, F_J, F_JR, F_LUI, F_AUIPC, F_NOP, F_BAD} fmt_e;

  exp_t q[$];

  // Reference decode: classify the format, then derive fields from RISC-V field arithmetic
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t        e;
    fmt_e        f;
    bit          ok;
    int          si;
    int          imm_i, imm_s, imm_b, imm_j;
    logic [31:0] imm_u;
    si    = $signed(ins);
    imm_i = si >>> 20;
    imm_s = (si >>> 25) * 32 + int'(ins[11:7]);
    imm_b = (si >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    imm_j = (si >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
    imm_u = ins & 32'hFFFFF000;
    ok = 1'b1;
    case (ins[6:0])
      7'h33: begin f = F_R; ok = (ins[31:25] == 7'h00) || (ins[31:25] == 7'h20 && (ins[14:12] == 3'd0 || ins[14:12] == 3'd5)); end
      7'h13: begin
        f = F_I;
        if (ins[14:12] == 3'd1) ok = (ins[31:25] == 7'h00);
        if (ins[14:12] == 3'd5) ok = (ins[31:25] == 7'h00) || (ins[31:25] == 7'h20);
      end
      7'h03: f = F_L;
      7'h23: f = F_S;
      7'h63: f = F_B;
      7'h6F: f = F_J;
      7'h67: begin f = F_JR; ok = (ins[14:12] == 3'd0); end
      7'h37: f = F_LUI;
      7'h17: f = F_AUIPC;
      7'h0F, 7'h73: begin f = F_NOP; ok = CSR_LEGAL; end
      default: begin f = F_BAD; ok = 1'b0; end
    endcase
    e = '0;
    e.pc = pc;
    e.funct3 = ins[14:12];
    e.funct7b5 = ins[30];
    if (!ok) begin
      e.illegal = 1'b1;
      return e;
    end
    if (f inside {F_R, F_I, F_L, F_S, F_B, F_JR}) e.rs1 = ins[19:15];
    if (f inside {F_R, F_S, F_B}) e.rs2 = ins[24:20];
    if (f inside {F_R, F_I, F_L, F_J, F_JR, F_LUI, F_AUIPC}) e.rd = ins[11:7];
    case (f)
      F_I, F_L, F_JR:   e.imm = imm_i;
      F_S:              e.imm = imm_s;
      F_B:              e.imm = imm_b;
      F_J:              e.imm = imm_j;
      F_LUI, F_AUIPC:   e.imm = imm_u;
      default:          e.imm = 32'd0;
    endcase
    e.alu2sel  = (f inside {F_I, F_L, F_LUI, F_AUIPC});
    e.alu1sel  = (f == F_AUIPC);
    e.pcsel    = (f == F_J) ? 2'd1 : (f == F_JR) ? 2'd2 : (f == F_B) ? 2'd3 : 2'd0;
    e.wbsel    = (f == F_L) ? 2'd1 : (f inside {F_J, F_JR}) ? 2'd2 : 2'd0;
    e.memread  = (f == F_L);
    e.memwrite = (f == F_S);
    e.regwrite = (e.rd != 5'd0);
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t a;
    a.pc = bus.out_pc;       a.pcsel = bus.pcsel;       a.alu1sel = bus.alu1sel;
    a.alu2sel = bus.alu2sel; a.wbsel = bus.wbsel;       a.regwrite = bus.regwrite;
    a.memread = bus.memread; a.memwrite = bus.memwrite; a.funct3 = bus.funct3;
    a.funct7b5 = bus.funct7b5; a.rs1 = bus.rs1; a.rs2 = bus.rs2; a.rd = bus.rd;
    a.imm = bus.imm;         a.illegal = bus.illegal;
    return a;
  endfunction

  task automatic chk1(input string name, input logic act, input logic req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic chkb(input string name, input exp_t act, input exp_t req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Compare process: occupancy and delivered bundles against the model every cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk1("reset_out_valid", bus.out_valid, 1'b0);
      chk1("reset_in_ready", bus.in_ready, 1'b1);
    end else begin
      chk1("out_valid_vs_model", bus.out_valid, q.size() > 0);
      chk1("in_ready_vs_model", bus.in_ready, q.size() < 2);
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        chkb("bundle", observed(), q.pop_front());
        npop++;
      end
      if (flush) q.delete();
      else if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_ins, bus.in_pc));
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_ins   = ins;
    bus.in_pc    = pc;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      nchk++; nerr++;
      $display("FAIL send_wait: in_ready=0 after 100 cycles, required 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while ((q.size() != 0 || bus.out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      nchk++; nerr++;
      $display("FAIL drain_wait: %0d entries still pending, required 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200us");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] tbl [14];
    logic [7:0]  pat;
    int          p0;
    tbl = '{32'h402081B3, 32'h4020D1B3, 32'h4020C1B3, 32'h022080B3, 32'h4010D093, 32'h02109093,
            32'h00008067, 32'h000090E7, 32'h0040A103, 32'h00001097, 32'h0000000F, 32'h00000073,
            32'h00000090, 32'hFFF00093};
    pat = 8'b1011_0010;
    bus.in_valid = 1'b0; bus.in_ins = '0; bus.in_pc = '0; bus.out_ready = 1'b1;
    flush = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk1("reset_lit_out_valid", bus.out_valid, 1'b0);
    chk1("reset_lit_in_ready", bus.in_ready, 1'b1);
    chk32("reset_lit_imm", bus.imm, 32'h0);
    chk32("reset_lit_rd", 32'(bus.rd), 32'h0);
    chk1("reset_lit_regwrite", bus.regwrite, 1'b0);
    chk32("reset_lit_pcsel", 32'(bus.pcsel), 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADDI x1,x0,-1
    send(32'hFFF00093, 32'h100);
    chk1("addi_out_valid", bus.out_valid, 1'b1);
    chk32("addi_rd", 32'(bus.rd), 32'd1);
    chk32("addi_imm", bus.imm, 32'hFFFFFFFF);
    chk1("addi_alu2sel", bus.alu2sel, 1'b1);
    chk1("addi_regwrite", bus.regwrite, 1'b1);

    // LUI x5,0x12345 then JAL x1,-4
    send(32'h123452B7, 32'h104);
    chk32("lui_imm", bus.imm, 32'h12345000);
    chk32("lui_rs1", 32'(bus.rs1), 32'd0);
    chk32("lui_rd", 32'(bus.rd), 32'd5);
    send(32'hFFDFF0EF, 32'h108);
    chk32("jal_imm", bus.imm, 32'hFFFFFFFC);
    chk32("jal_pcsel", 32'(bus.pcsel), 32'd1);
    chk32("jal_wbsel", 32'(bus.wbsel), 32'd2);

    // BEQ x1,x2,+8 then SW x2,12(x1)
    send(32'h00208463, 32'h10C);
    chk32("beq_imm", bus.imm, 32'd8);
    chk32("beq_pcsel", 32'(bus.pcsel), 32'd3);
    chk1("beq_regwrite", bus.regwrite, 1'b0);
    chk32("beq_rs2", 32'(bus.rs2), 32'd2);
    send(32'h0020A623, 32'h110);
    chk32("sw_imm", bus.imm, 32'd12);
    chk1("sw_memwrite", bus.memwrite, 1'b1);

    // all-zero word and ADDI x0
    send(32'h00000000, 32'h114);
    chk1("zero_illegal", bus.illegal, 1'b1);
    chk1("zero_regwrite", bus.regwrite, 1'b0);
    send(32'h00100013, 32'h118);
    chk1("addi_x0_illegal", bus.illegal, 1'b0);
    chk1("addi_x0_regwrite", bus.regwrite, 1'b0);
    drain();

    // Four-deep stream against three stalled cycles
    p0 = npop;
    bus.out_ready = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
      begin
        send(32'h00100093, 32'h200);
        send(32'h00200113, 32'h204);
        chk1("stall_in_ready_low", bus.in_ready, 1'b0);
        chk1("stall_out_valid", bus.out_valid, 1'b1);
        send(32'h00300193, 32'h208);
        send(32'h00400213, 32'h20C);
      end
    join
    drain();
    chk32("stall_delivered_count", 32'(npop - p0), 32'd4);

    // Format/illegal table under a bursty out_ready pattern
    fork
      begin
        for (int c = 0; c < 60; c++) begin
          bus.out_ready = pat[c % 8];
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 14; i++) send(tbl[i], 32'h3000 + 32'(i) * 4);
      end
    join
    drain();

    // Flush with output and skid both occupied
    bus.out_ready = 1'b0;
    send(32'h00500293, 32'h400);
    send(32'h00600313, 32'h404);
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_ins = 32'h00700393; bus.in_pc = 32'h408;
    @(posedge clk);
    #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    chk1("flush_out_valid", bus.out_valid, 1'b0);
    chk1("flush_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    // An instruction offered during flush while ready must be dropped
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_ins = 32'h00800413; bus.in_pc = 32'h40C;
    @(posedge clk);
    #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    chk1("flush_drop_out_valid", bus.out_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    send(32'h00900493, 32'h500);
    send(32'h00A00513, 32'h504);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst_out_valid", bus.out_valid, 1'b0);
    chk1("async_rst_in_ready", bus.in_ready, 1'b1);
    chk32("async_rst_imm", bus.imm, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    send(32'hFFF00093, 32'h600);
    chk1("post_rst_out_valid", bus.out_valid, 1'b1);
    chk32("post_rst_pc", bus.out_pc, 32'h600);
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
